// File: rtl/lt24_pkg.sv
// Shared definitions for the LT24 LCD responder: command opcodes, panel
// geometry defaults, the command FSM state type and the debug view.
package lt24_pkg;

  localparam int H_RES_DEF = 240;
  localparam int V_RES_DEF = 320;

  localparam logic [7:0] OP_SWRESET = 8'h01;
  localparam logic [7:0] OP_SLPIN   = 8'h10;
  localparam logic [7:0] OP_SLPOUT  = 8'h11;
  localparam logic [7:0] OP_DISPOFF = 8'h28;
  localparam logic [7:0] OP_DISPON  = 8'h29;
  localparam logic [7:0] OP_CASET   = 8'h2A;
  localparam logic [7:0] OP_PASET   = 8'h2B;
  localparam logic [7:0] OP_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CASET_P,
    ST_PASET_P,
    ST_RAMWR,
    ST_IGNORE
  } lt24_state_e;

  typedef struct packed {
    lt24_state_e state;
    logic [1:0]  param_cnt;
    logic        csx_s;
    logic        rdx_s;
  } lt24_dbg_t;

endpackage

// File: rtl/lt24_bus_sync.sv
// Two-flop synchronizer for the asynchronous 8080 host bus plus detection of
// the write strobe rising edge while chip select is active.
module lt24_bus_sync (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        soft_rst_n,
  input  logic        tft_csx,
  input  logic        tft_dcx,
  input  logic        tft_wrx,
  input  logic        tft_rdx,
  input  logic [15:0] tft_data,
  output logic        wr_evt,
  output logic        dcx_s,
  output logic        csx_s,
  output logic        rdx_s,
  output logic [15:0] data_s
);

  logic [1:0]  csx_ff;
  logic [1:0]  dcx_ff;
  logic [1:0]  wrx_ff;
  logic [1:0]  rdx_ff;
  logic [15:0] data_ff0;
  logic [15:0] data_ff1;
  logic        wrx_d;

  // Reset loads idle bus levels so no phantom strobe edge appears afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csx_ff   <= 2'b11;
      dcx_ff   <= 2'b11;
      wrx_ff   <= 2'b11;
      rdx_ff   <= 2'b11;
      data_ff0 <= '0;
      data_ff1 <= '0;
      wrx_d    <= 1'b1;
    end else if (!soft_rst_n) begin
      csx_ff   <= 2'b11;
      dcx_ff   <= 2'b11;
      wrx_ff   <= 2'b11;
      rdx_ff   <= 2'b11;
      data_ff0 <= '0;
      data_ff1 <= '0;
      wrx_d    <= 1'b1;
    end else begin
      csx_ff   <= {csx_ff[0], tft_csx};
      dcx_ff   <= {dcx_ff[0], tft_dcx};
      wrx_ff   <= {wrx_ff[0], tft_wrx};
      rdx_ff   <= {rdx_ff[0], tft_rdx};
      data_ff0 <= tft_data;
      data_ff1 <= data_ff0;
      wrx_d    <= wrx_ff[1];
    end
  end

  // wr_evt is a single-cycle event with no backpressure: the host keeps data
  // and dcx stable for several clocks after the strobe rises, so data_s and
  // dcx_s are valid in the same cycle as wr_evt.
  assign wr_evt = wrx_ff[1] & ~wrx_d & ~csx_ff[1];
  assign dcx_s  = dcx_ff[1];
  assign csx_s  = csx_ff[1];
  assign rdx_s  = rdx_ff[1];
  assign data_s = data_ff1;

endmodule

// File: rtl/lt24_lcd_responder.sv
// Responder for an ILI9341-style 8080 command stream: tracks the address
// window, streams RAMWR pixels out as addressed writes, and keeps panel flags.
module lt24_lcd_responder
  import lt24_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tft_rst,
  input  logic        tft_csx,
  input  logic        tft_dcx,
  input  logic        tft_wrx,
  input  logic        tft_rdx,
  input  logic [15:0] tft_data,
  output logic        pix_we,
  output logic [7:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        display_on,
  output logic        sleep_out,
  output logic        frame_done,
  output lt24_dbg_t   dbg
);

  logic        wr_evt;
  logic        dcx_s;
  logic        csx_s;
  logic        rdx_s;
  logic [15:0] data_s;

  lt24_bus_sync u_bus_sync (
    .clk        (clk),
    .reset_n    (reset_n),
    .soft_rst_n (tft_rst),
    .tft_csx    (tft_csx),
    .tft_dcx    (tft_dcx),
    .tft_wrx    (tft_wrx),
    .tft_rdx    (tft_rdx),
    .tft_data   (tft_data),
    .wr_evt     (wr_evt),
    .dcx_s      (dcx_s),
    .csx_s      (csx_s),
    .rdx_s      (rdx_s),
    .data_s     (data_s)
  );

  lt24_state_e state;
  lt24_state_e state_nxt;

  logic        cmd_evt;
  logic        dat_evt;
  logic [7:0]  op;
  logic [1:0]  pcnt;
  logic [23:0] pbuf;
  logic [15:0] sc, ec, sp, ep;
  logic [15:0] cur_x, cur_y;
  logic        x_end, y_end, in_range;
  logic        soft_clr;

  assign cmd_evt  = wr_evt & ~dcx_s;
  assign dat_evt  = wr_evt & dcx_s;
  assign op       = data_s[7:0];
  assign x_end    = (cur_x == ec);
  assign y_end    = (cur_y == ep);
  assign in_range = (cur_x < 16'(H_RES)) && (cur_y < 16'(V_RES));
  assign soft_clr = ~tft_rst | (cmd_evt & (op == OP_SWRESET));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      state <= ST_IDLE;
    else if (!tft_rst) state <= ST_IDLE;
    else               state <= state_nxt;
  end

  // Any command preempts whatever parameter or pixel sequence is in flight.
  always_comb begin
    state_nxt = state;
    if (cmd_evt) begin
      case (op)
        OP_CASET:   state_nxt = ST_CASET_P;
        OP_PASET:   state_nxt = ST_PASET_P;
        OP_RAMWR:   state_nxt = ST_RAMWR;
        OP_SWRESET, OP_SLPIN, OP_SLPOUT, OP_DISPOFF, OP_DISPON:
                    state_nxt = ST_IDLE;
        default:    state_nxt = ST_IGNORE;
      endcase
    end else if (dat_evt && (pcnt == 2'd3) &&
                 ((state == ST_CASET_P) || (state == ST_PASET_P))) begin
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_we     <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      frame_done <= 1'b0;
      display_on <= 1'b0;
      sleep_out  <= 1'b0;
      pcnt       <= '0;
      pbuf       <= '0;
      sc         <= '0;
      ec         <= 16'(H_RES - 1);
      sp         <= '0;
      ep         <= 16'(V_RES - 1);
      cur_x      <= '0;
      cur_y      <= '0;
    end else begin
      pix_we     <= 1'b0;
      frame_done <= 1'b0;
      if (soft_clr) begin
        pix_x      <= '0;
        pix_y      <= '0;
        pix_data   <= '0;
        display_on <= 1'b0;
        sleep_out  <= 1'b0;
        pcnt       <= '0;
        pbuf       <= '0;
        sc         <= '0;
        ec         <= 16'(H_RES - 1);
        sp         <= '0;
        ep         <= 16'(V_RES - 1);
        cur_x      <= '0;
        cur_y      <= '0;
      end else if (cmd_evt) begin
        pcnt <= '0;
        case (op)
          OP_SLPOUT:  sleep_out  <= 1'b1;
          OP_SLPIN:   sleep_out  <= 1'b0;
          OP_DISPON:  display_on <= 1'b1;
          OP_DISPOFF: display_on <= 1'b0;
          OP_RAMWR: begin
            cur_x <= sc;
            cur_y <= sp;
          end
          default: ;
        endcase
      end else if (dat_evt) begin
        case (state)
          ST_CASET_P, ST_PASET_P: begin
            // Shadow the first three bytes; the fourth commits start and end together.
            pcnt <= pcnt + 2'd1;
            pbuf <= {pbuf[15:0], data_s[7:0]};
            if (pcnt == 2'd3) begin
              if (state == ST_CASET_P) begin
                sc <= pbuf[23:8];
                ec <= {pbuf[7:0], data_s[7:0]};
              end else begin
                sp <= pbuf[23:8];
                ep <= {pbuf[7:0], data_s[7:0]};
              end
            end
          end
          ST_RAMWR: begin
            pix_we   <= in_range;
            pix_x    <= cur_x[7:0];
            pix_y    <= cur_y[8:0];
            pix_data <= data_s;
            // Off-panel pixels are dropped but still consume a cursor position.
            if (!x_end) begin
              cur_x <= cur_x + 16'd1;
            end else if (!y_end) begin
              cur_x <= sc;
              cur_y <= cur_y + 16'd1;
            end else begin
              frame_done <= 1'b1;
              cur_x      <= sc;
              cur_y      <= sp;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dbg = '{state: state, param_cnt: pcnt, csx_s: csx_s, rdx_s: rdx_s};

endmodule
